// File: rtl/fb_port_arbiter_pkg.sv
// Shared framebuffer definitions: geometry and the clear-sequencer state encoding.
package fb_pkg;

  localparam int FRAMEBUFFER_SIZE = 640 * 480;
  localparam int FB_ADDR_W        = 19;
  localparam int FB_DATA_W        = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Bus bundle between the arbiter and its clients (scanout, renderer, clear control, RAM).
interface fb_port_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              vga_valid;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clr_start;
  logic [DATA_W-1:0] clr_index;
  logic              clr_busy;
  logic              clr_done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  vga_req, vga_addr, wr_valid, wr_addr, wr_data, clr_start, clr_index, ram_rdata,
    output vga_data, vga_valid, wr_ready, clr_busy, clr_done, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output vga_req, vga_addr, wr_valid, wr_addr, wr_data, clr_start, clr_index, ram_rdata,
    input  vga_data, vga_valid, wr_ready, clr_busy, clr_done, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/fb_clear_engine.sv
// Clear sequencer: walks clr_ptr from 0 to DEPTH-1, one word per granted cycle.
//   state | meaning
//   IDLE  | no clear running; start is accepted
//   CLEAR | fill in progress; ptr is the next word to write
module fb_clear_engine
  import fb_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4,
  parameter int DEPTH  = FRAMEBUFFER_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              advance,
  input  logic [DATA_W-1:0] index_in,
  output logic              busy,
  output logic [ADDR_W-1:0] ptr,
  output logic              last,
  output logic              done,
  output logic [DATA_W-1:0] index
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  fb_state_t state, state_next;
  logic      accept;

  assign accept = start && (state == IDLE);
  assign busy   = (state == CLEAR);
  assign last   = busy && (ptr == LAST_PTR);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: leave CLEAR only once the final word has been written.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   if (advance && last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pointer holds at DEPTH-1 after the last write so it can never wrap.
  always_ff @(posedge clk) begin
    if (reset)                 ptr <= '0;
    else if (accept)           ptr <= '0;
    else if (advance && !last) ptr <= ptr + 1'b1;
  end

  // Fill value captured only when a clear is accepted.
  always_ff @(posedge clk) begin
    if (reset)       index <= '0;
    else if (accept) index <= index_in;
  end

  // One-cycle completion pulse in the cycle after the last write.
  always_ff @(posedge clk) begin
    if (reset) done <= 1'b0;
    else       done <= advance && last;
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: scanout reads always win, then clear, then renderer writes.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int DEPTH  = FRAMEBUFFER_SIZE
) (
  input  logic           clk,
  input  logic           reset,
  fb_port_arbiter_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic              clr_advance;
  logic              clr_last;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] clr_fill;

  fb_clear_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_clear (
    .clk      (clk),
    .reset    (reset),
    .start    (bus.clr_start),
    .advance  (clr_advance),
    .index_in (bus.clr_index),
    .busy     (bus.clr_busy),
    .ptr      (clr_ptr),
    .last     (clr_last),
    .done     (bus.clr_done),
    .index    (clr_fill)
  );

  assign bus.vga_data = bus.ram_rdata;

  // Read data from the RAM is valid one cycle after the scanout request.
  always_ff @(posedge clk) begin
    if (reset) bus.vga_valid <= 1'b0;
    else       bus.vga_valid <= bus.vga_req;
  end

  // RAM port mux and grants; nothing is granted while reset is held.
  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    bus.wr_ready  = 1'b0;
    clr_advance   = 1'b0;
    if (!reset) begin
      if (bus.vga_req) begin
        bus.ram_addr = bus.vga_addr;
      end else if (bus.clr_busy) begin
        bus.ram_addr  = clr_ptr;
        bus.ram_we    = 1'b1;
        bus.ram_wdata = clr_fill;
        clr_advance   = 1'b1;
      end else if (bus.wr_valid) begin
        bus.wr_ready  = 1'b1;
        bus.ram_addr  = bus.wr_addr;
        bus.ram_wdata = bus.wr_data;
        bus.ram_we    = ({1'b0, bus.wr_addr} < DEPTH_X);
      end
    end
  end

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Arbiter and sequencer for the single-port framebuffer RAM. Shares the RAM between the VGA scanout path, the renderer write port, and an internal clear engine that fills the whole framebuffer with one colour index. Sits between the screen driver's colour stage (palette index fetch) and the framebuffer RAM. VGA reads are never stalled; all other traffic uses the cycles left over.

## Interface
Parameters:
- `ADDR_W`, 19: framebuffer address width.
- `DATA_W`, 4: colour-index width (16-entry palette).
- `DEPTH`, `FRAMEBUFFER_SIZE` (from `params.vh`): number of valid RAM words; addresses `>= DEPTH` are out of range.

Ports:
- `clk` in 1: system clock. One clock domain; no other clocks.
- `reset` in 1: synchronous, active-high.
- `vga_req` in 1: scanout read request this cycle; no handshake, always served.
- `vga_addr` in ADDR_W: scanout read address.
- `vga_data` out DATA_W: read data; equals `ram_rdata`.
- `vga_valid` out 1: `vga_data` holds the result of the previous cycle's `vga_req`.
- `wr_valid` in 1: renderer write request.
- `wr_ready` out 1: write accepted this cycle.
- `wr_addr` in ADDR_W: renderer write address.
- `wr_data` in DATA_W: renderer write data.
- `clr_start` in 1: start a full-framebuffer clear.
- `clr_index` in DATA_W: fill value; sampled on an accepted `clr_start`.
- `clr_busy` out 1: clear in progress.
- `clr_done` out 1: one-cycle pulse when a clear completes.
- `ram_addr` out ADDR_W: RAM address.
- `ram_we` out 1: RAM write enable.
- `ram_wdata` out DATA_W: RAM write data.
- `ram_rdata` in DATA_W: RAM read data, one-cycle synchronous read latency.

## Operation
- **States:** `IDLE` and `CLEAR`.
- **Starting a clear:** `clr_start` in `IDLE` latches `clr_index`, zeroes `clr_ptr` and moves to `CLEAR`. `clr_start` while in `CLEAR` is ignored.
- **Per-cycle priority:**
  1. `vga_req`: `ram_addr = vga_addr`, `ram_we = 0`.
  2. Otherwise, in `CLEAR`: `ram_addr = clr_ptr`, `ram_we = 1`, `ram_wdata = latched index`, then `clr_ptr` increments.
  3. Otherwise, in `IDLE` with `wr_valid`: `wr_ready = 1`, `ram_addr = wr_addr`, `ram_wdata = wr_data`.
- **Renderer writes:** `ram_we = 1` only if `wr_addr < DEPTH`. Out-of-range writes are still accepted (`wr_ready = 1`) and silently dropped.
- **Combinational outputs:** `wr_ready`, `ram_addr`, `ram_we` and `ram_wdata` are combinational from the current inputs and state.
- **Idle RAM port:** when nothing is granted, `ram_addr = 0` and `ram_we = 0`.
- **Clear completion:** the cycle that writes `clr_ptr == DEPTH-1` returns to `IDLE`. Next cycle: `clr_busy = 0` and `clr_done = 1` for exactly one cycle.
- **Stalled clear:** a `vga_req` cycle in `CLEAR` does not advance `clr_ptr`.
- **Out-of-range VGA reads:** VGA addresses are not range-checked here. The colour stage already maps blanking to address 0.
- **`clr_ptr` width:** ADDR_W, compared against `DEPTH-1`. It must never wrap.

## Timing
- **Reset values:** `clr_busy = 0`, `clr_done = 0`, `vga_valid = 0`, `ram_we = 0`, `ram_addr = 0`, `wr_ready = 0`. State `IDLE`, `clr_ptr = 0`.
- **While `reset` is high:** `wr_ready = 0`, and no request is granted.
- **VGA read latency:** `vga_req` at cycle N gives `vga_valid = 1` at N+1 with `vga_data = ram_rdata`.
- **`vga_valid`:** a register; `vga_valid(N+1) = vga_req(N)`.
- **Writes:** each accepted write reaches the RAM in the same cycle (`ram_we` high at N).
- **Clear duration:** with no VGA traffic, `clr_start` at N gives writes N+1 … N+DEPTH and `clr_done` at N+DEPTH+1.
- **`clr_busy`:** high from N+1 through N+DEPTH.
- **`clr_start` + `wr_valid` in the same cycle:** the write is granted that cycle; `CLEAR` begins next cycle.
- **`vga_req` + `wr_valid` in the same cycle:** `wr_ready = 0`. The writer must hold address and data until accepted.
- **Reset mid-clear:** aborts to `IDLE`. No `clr_done` pulse; memory is left partially cleared.

## Structure
- `DEPTH` and the address width come from `FRAMEBUFFER_SIZE` in `params.vh`.
- The state enum (`IDLE`, `CLEAR`) goes in a shared package `fb_pkg`, so the renderer and bench can reference it.
- One sub-module, `fb_clear_engine`: holds the `clr_ptr` counter, latched index and done pulse. Inputs are `start` and `advance`; outputs are `busy`, `ptr`, `last` and `done`.
- Arbitration and the RAM mux stay in the top module.

## Test plan
- **Scanout read:** `vga_req = 1`, `vga_addr = 1234` for one cycle, RAM holds 4'h7 there -> next cycle `vga_valid = 1`, `vga_data = 4'h7`. No write occurs that cycle.
- **Write blocked then accepted:** `wr_valid = 1`, `wr_addr = 100`, `wr_data = 4'hA`, with `vga_req` high for 3 cycles -> `wr_ready = 0` for 3 cycles, then 1. RAM[100] = A.
- **Out-of-range write:** `wr_addr = DEPTH` -> `wr_ready = 1`, `ram_we = 0`, memory unchanged.
- **Full clear:** `clr_index = 4'h3`, VGA idle -> all DEPTH words = 3. `clr_done` pulses exactly once, at cycle DEPTH+1. `wr_ready = 0` throughout `clr_busy`.
- **Clear with interleaved VGA:** `vga_req` asserted every 2nd cycle -> the clear takes 2·DEPTH cycles and every VGA read returns `vga_valid` at N+1. A second `clr_start` mid-clear is ignored.
- **Reset mid-clear:** `reset` at `clr_ptr = 500` -> next cycle `clr_busy = 0`, no `clr_done`, words ≥ 500 untouched.
